// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the multi-cycle hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    localparam int unsigned DEF_REG_AW      = 5;
    localparam int unsigned DEF_MUL_LAT     = 4;
    localparam int unsigned DEF_DIV_LAT     = 32;
    localparam int unsigned DEF_STALL_CNT_W = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hilo_tracker.sv
// Tracks occupancy of the multi-cycle HI/LO unit (mult/div) with a
// two-state FSM and a latency down-counter.
module hilo_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mc_start_e,
    input  logic mc_isdiv_e,
    output logic mc_busy,
    output logic mc_done,
    output logic mc_cnt_gt1
);

    localparam int unsigned CNT_W = $clog2(max_u(MUL_LAT, DIV_LAT) + 1);

    mc_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   start_lat;

    assign start_lat = mc_isdiv_e ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start while BUSY reloads: legal on the release cycle (cnt==1),
    // a protocol violation otherwise, but handled identically.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (mc_start_e) begin
                    state_nxt = BUSY;
                    cnt_nxt   = start_lat;
                end
            end
            BUSY: begin
                if (mc_start_e) begin
                    cnt_nxt = start_lat;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign mc_busy    = (state == BUSY);
    assign mc_done    = (state == BUSY) && (cnt == CNT_W'(1));
    assign mc_cnt_gt1 = (state == BUSY) && (cnt > CNT_W'(1));

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use/branch
// stalls, HI/LO unit stalls, branch/jump flush and a stall-cycle counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = DEF_REG_AW,
    parameter int unsigned MUL_LAT     = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT     = DEF_DIV_LAT,
    parameter int unsigned STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REG_AW-1:0]      rs_d,
    input  logic [REG_AW-1:0]      rt_d,
    input  logic [REG_AW-1:0]      rs_e,
    input  logic [REG_AW-1:0]      rt_e,
    input  logic [REG_AW-1:0]      writereg_e,
    input  logic [REG_AW-1:0]      writereg_m,
    input  logic [REG_AW-1:0]      writereg_w,
    input  logic                   regwrite_e,
    input  logic                   regwrite_m,
    input  logic                   regwrite_w,
    input  logic                   memtoreg_e,
    input  logic                   memtoreg_m,
    input  logic                   branch_d,
    input  logic                   pcsrc_d,
    input  logic                   jump_d,
    input  logic                   mc_start_d,
    input  logic                   mc_start_e,
    input  logic                   mc_isdiv_e,
    input  logic                   hilo_rd_d,
    input  logic                   stat_clr,
    output logic [1:0]             forward_a_e,
    output logic [1:0]             forward_b_e,
    output logic                   forward_a_d,
    output logic                   forward_b_d,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   flush_e,
    output logic                   flush_d,
    output logic                   mc_busy,
    output logic                   mc_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic mc_cnt_gt1;
    logic lwstall, branchstall, mcstall, stall;

    function automatic fwd_sel_t fwd_e_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wr_m,
        input logic              rw_m,
        input logic [REG_AW-1:0] wr_w,
        input logic              rw_w
    );
        if (src != '0 && rw_m && src == wr_m)
            return FWD_M;
        else if (src != '0 && rw_w && src == wr_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    assign forward_a_e = fwd_e_sel(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
    assign forward_b_e = fwd_e_sel(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
    assign forward_a_d = (rs_d != '0) && regwrite_m && (rs_d == writereg_m);
    assign forward_b_d = (rt_d != '0) && regwrite_m && (rt_d == writereg_m);

    assign lwstall = memtoreg_e && (writereg_e != '0) &&
                     ((rs_d == writereg_e) || (rt_d == writereg_e));

    assign branchstall = branch_d &&
        ((regwrite_e && (writereg_e != '0) && ((rs_d == writereg_e) || (rt_d == writereg_e))) ||
         (memtoreg_m && (writereg_m != '0) && ((rs_d == writereg_m) || (rt_d == writereg_m))));

    hilo_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_hilo_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .mc_start_e (mc_start_e),
        .mc_isdiv_e (mc_isdiv_e),
        .mc_busy    (mc_busy),
        .mc_done    (mc_done),
        .mc_cnt_gt1 (mc_cnt_gt1)
    );

    // On the final busy cycle the result is ready, so HI/LO readers proceed.
    assign mcstall = (hilo_rd_d || mc_start_d) && (mc_start_e || mc_cnt_gt1);

    assign stall   = lwstall || branchstall || mcstall;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;
    assign flush_d = (pcsrc_d || jump_d) && !stall;

    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc against a remaining-cycles model.
module tb_hazard_unit_mc;

    localparam int REG_AW   = 5;
    localparam int MUL      = 4;
    localparam int DIV      = 32;
    localparam int SCW      = 4;
    localparam int SCNT_MAX = 15;

    logic clk;
    logic reset_n;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic branch_d, pcsrc_d, jump_d, mc_start_d, mc_start_e, mc_isdiv_e, hilo_rd_d, stat_clr;
    logic [1:0] forward_a_e, forward_b_e;
    logic forward_a_d, forward_b_d, stall_f, stall_d, flush_e, flush_d, mc_busy, mc_done;
    logic [SCW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;
    int rem   = 0;   // cycles the HI/LO unit still owns
    int scnt  = 0;   // expected stall count

    hazard_unit_mc #(
        .REG_AW      (REG_AW),
        .MUL_LAT     (MUL),
        .DIV_LAT     (DIV),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .pcsrc_d(pcsrc_d), .jump_d(jump_d),
        .mc_start_d(mc_start_d), .mc_start_e(mc_start_e), .mc_isdiv_e(mc_isdiv_e),
        .hilo_rd_d(hilo_rd_d), .stat_clr(stat_clr),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .flush_d(flush_d),
        .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_fwd_e(input logic [REG_AW-1:0] s);
        if (s == 0) return 2'd0;
        if (regwrite_m && s == writereg_m) return 2'd2;
        if (regwrite_w && s == writereg_w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic uses(input logic [REG_AW-1:0] r);
        return (r != 0) && (rs_d == r || rt_d == r);
    endfunction

    function automatic logic exp_stall();
        logic lw, br, mc;
        lw = memtoreg_e && uses(writereg_e);
        br = branch_d && ((regwrite_e && uses(writereg_e)) || (memtoreg_m && uses(writereg_m)));
        mc = (hilo_rd_d || mc_start_d) && (mc_start_e || rem > 1);
        return lw || br || mc;
    endfunction

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) begin
        logic st;
        st = exp_stall();
        if (reset_n && mc_start_e && rem > 1) begin
            fails++;
            $display("FAIL protocol: mc_start_e while busy, remaining=%0d required<=1", rem);
        end
        if (!reset_n) begin
            rem  = 0;
            scnt = 0;
        end else begin
            if (stat_clr) scnt = 0;
            else if (st && scnt < SCNT_MAX) scnt++;
            if (mc_start_e) rem = mc_isdiv_e ? DIV : MUL;
            else if (rem > 0) rem--;
        end
    end

    task automatic idle_inputs();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        writereg_e = 0; writereg_m = 0; writereg_w = 0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0;
        branch_d = 0; pcsrc_d = 0; jump_d = 0;
        mc_start_d = 0; mc_start_e = 0; mc_isdiv_e = 0; hilo_rd_d = 0; stat_clr = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && rem != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (mc_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", mc_busy); end
        tests++; if (mc_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", mc_done); end
        tests++; if (stall_cnt !== '0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        writereg_m = 8; regwrite_m = 1; rs_e = 8;
        #1;
        tests++; if (forward_a_e !== 2'b10) begin fails++; $display("FAIL reset_comb_fwd got=%b exp=10", forward_a_e); end
        idle_inputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_forward_priority();
        @(negedge clk);
        idle_inputs();
        writereg_m = 8; writereg_w = 8; regwrite_m = 1; regwrite_w = 1; rs_e = 8; rt_e = 8; rs_d = 8;
        #1;
        tests++; if (forward_a_e !== 2'b10) begin fails++; $display("FAIL fwd_m_prio got=%b exp=10", forward_a_e); end
        tests++; if (forward_b_e !== 2'b10) begin fails++; $display("FAIL fwd_b_m got=%b exp=10", forward_b_e); end
        tests++; if (forward_a_d !== 1'b1) begin fails++; $display("FAIL fwd_a_d got=%b exp=1", forward_a_d); end
        regwrite_m = 0;
        #1;
        tests++; if (forward_a_e !== 2'b01) begin fails++; $display("FAIL fwd_w got=%b exp=01", forward_a_e); end
        tests++; if (forward_a_d !== 1'b0) begin fails++; $display("FAIL fwd_a_d_off got=%b exp=0", forward_a_d); end
        rs_e = 0; writereg_w = 0;
        #1;
        tests++; if (forward_a_e !== 2'b00) begin fails++; $display("FAIL fwd_zero got=%b exp=00", forward_a_e); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs();
        memtoreg_e = 1; writereg_e = 9; rt_d = 9;
        #1;
        tests++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin fails++; $display("FAIL lw_stall got=%b exp=111", {stall_f, stall_d, flush_e}); end
        @(negedge clk);
        writereg_e = 0; rt_d = 0;
        #1;
        tests++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin fails++; $display("FAIL lw_r0 got=%b exp=000", {stall_f, stall_d, flush_e}); end
    endtask

    task automatic test_branch_flush();
        @(negedge clk);
        idle_inputs();
        branch_d = 1; pcsrc_d = 1; rs_d = 4; regwrite_e = 1; writereg_e = 4;
        #1;
        tests++; if ({stall_d, flush_d} !== 2'b10) begin fails++; $display("FAIL br_stall got=%b exp=10", {stall_d, flush_d}); end
        @(negedge clk);
        regwrite_e = 0; memtoreg_m = 1; writereg_m = 4;
        #1;
        tests++; if ({stall_d, flush_d} !== 2'b10) begin fails++; $display("FAIL br_stall_ldm got=%b exp=10", {stall_d, flush_d}); end
        @(negedge clk);
        memtoreg_m = 0;
        #1;
        tests++; if ({stall_d, flush_d} !== 2'b01) begin fails++; $display("FAIL br_flush got=%b exp=01", {stall_d, flush_d}); end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++; if (flush_d !== 1'b0) begin fails++; $display("FAIL br_flush_once got=%b exp=0", flush_d); end
        jump_d = 1; regwrite_e = 1; writereg_e = 4; rs_d = 4;
        #1;
        tests++; if ({stall_d, flush_d} !== 2'b01) begin fails++; $display("FAIL jump_flush got=%b exp=01", {stall_d, flush_d}); end
    endtask

    task automatic test_mc(input logic isdiv, input int lat);
        int stalls;
        @(negedge clk);
        idle_inputs();
        wait_idle();
        mc_start_e = 1; mc_isdiv_e = isdiv; hilo_rd_d = 1;
        #1;
        stalls = stall_f ? 1 : 0;
        tests++; if (stall_f !== 1'b1 || mc_busy !== 1'b0) begin fails++; $display("FAIL mc_issue div=%0b stall=%b busy=%b exp 1,0", isdiv, stall_f, mc_busy); end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            mc_start_e = 0;
            #1;
            if (stall_f) stalls++;
            tests++;
            if (mc_busy !== 1'b1 || mc_done !== (k == lat) || stall_f !== (k < lat)) begin
                fails++;
                $display("FAIL mc_cycle div=%0b k=%0d busy=%b done=%b stall=%b exp 1,%b,%b",
                         isdiv, k, mc_busy, mc_done, stall_f, (k == lat), (k < lat));
            end
        end
        @(negedge clk);
        #1;
        tests++; if (mc_busy !== 1'b0 || stall_f !== 1'b0) begin fails++; $display("FAIL mc_after div=%0b busy=%b stall=%b exp 0,0", isdiv, mc_busy, stall_f); end
        tests++; if (stalls !== lat) begin fails++; $display("FAIL mc_stall_count div=%0b got=%0d exp=%0d", isdiv, stalls, lat); end
        hilo_rd_d = 0;
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        idle_inputs();
        wait_idle();
        mc_start_e = 1; mc_isdiv_e = 1;
        @(negedge clk);
        mc_start_e = 0;
        for (int i = 0; i < 40 && rem != 17; i++) @(negedge clk);
        reset_n = 0; hilo_rd_d = 1;
        #1;
        tests++; if (stall_f !== 1'b1) begin fails++; $display("FAIL rst_div_pre stall got=%b exp=1", stall_f); end
        @(negedge clk);
        #1;
        tests++; if (mc_busy !== 1'b0 || stall_cnt !== '0) begin fails++; $display("FAIL rst_div busy=%b cnt=%0d exp 0,0", mc_busy, stall_cnt); end
        tests++; if (stall_f !== 1'b0) begin fails++; $display("FAIL rst_div_mfhi stall got=%b exp=0", stall_f); end
        reset_n = 1;
        @(negedge clk);
        #1;
        tests++; if (stall_f !== 1'b0 || mc_busy !== 1'b0) begin fails++; $display("FAIL rst_div_after stall=%b busy=%b exp 0,0", stall_f, mc_busy); end
        hilo_rd_d = 0;
    endtask

    task automatic test_stall_counter();
        @(negedge clk);
        idle_inputs();
        stat_clr = 1;
        @(negedge clk);
        stat_clr = 0;
        #1;
        tests++; if (stall_cnt !== '0) begin fails++; $display("FAIL cnt_clr got=%0d exp=0", stall_cnt); end
        memtoreg_e = 1; writereg_e = 9; rt_d = 9;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL cnt_sat got=%0d exp=15", stall_cnt); end
        stat_clr = 1;
        @(negedge clk);
        #1;
        tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL cnt_clr_prio got=%0d exp=0", stall_cnt); end
        stat_clr = 0;
        @(negedge clk);
        #1;
        tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL cnt_resume got=%0d exp=1", stall_cnt); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic       es;
        logic [1:0] fa, fb;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reset_n    = ($urandom_range(0, 59) != 0);
            rs_d       = REG_AW'($urandom_range(0, 3));
            rt_d       = REG_AW'($urandom_range(0, 3));
            rs_e       = REG_AW'($urandom_range(0, 3));
            rt_e       = REG_AW'($urandom_range(0, 3));
            writereg_e = REG_AW'($urandom_range(0, 3));
            writereg_m = REG_AW'($urandom_range(0, 3));
            writereg_w = REG_AW'($urandom_range(0, 3));
            {regwrite_e, regwrite_m, regwrite_w} = 3'($urandom);
            memtoreg_e = ($urandom_range(0, 3) == 0);
            memtoreg_m = ($urandom_range(0, 3) == 0);
            branch_d   = ($urandom_range(0, 2) == 0);
            pcsrc_d    = branch_d & 1'($urandom);
            jump_d     = ($urandom_range(0, 7) == 0);
            mc_start_d = ($urandom_range(0, 5) == 0);
            hilo_rd_d  = ($urandom_range(0, 2) == 0);
            mc_isdiv_e = ($urandom_range(0, 3) == 0);
            mc_start_e = (rem <= 1) && ($urandom_range(0, 4) == 0);
            stat_clr   = ($urandom_range(0, 40) == 0);
            #1;
            es = exp_stall();
            fa = exp_fwd_e(rs_e);
            fb = exp_fwd_e(rt_e);
            tests++;
            if (forward_a_e !== fa || forward_b_e !== fb ||
                forward_a_d !== (rs_d != 0 && regwrite_m && rs_d == writereg_m) ||
                forward_b_d !== (rt_d != 0 && regwrite_m && rt_d == writereg_m)) begin
                fails++;
                $display("FAIL rnd_fwd n=%0d a_e=%b b_e=%b a_d=%b b_d=%b exp a_e=%b b_e=%b", n,
                         forward_a_e, forward_b_e, forward_a_d, forward_b_d, fa, fb);
            end
            tests++;
            if (stall_f !== es || stall_d !== es || flush_e !== es ||
                flush_d !== ((pcsrc_d || jump_d) && !es)) begin
                fails++;
                $display("FAIL rnd_ctl n=%0d stall_f=%b stall_d=%b flush_e=%b flush_d=%b exp stall=%b", n,
                         stall_f, stall_d, flush_e, flush_d, es);
            end
            tests++;
            if (mc_busy !== (rem > 0) || mc_done !== (rem == 1) || stall_cnt !== SCW'(scnt)) begin
                fails++;
                $display("FAIL rnd_state n=%0d busy=%b done=%b cnt=%0d exp busy=%b done=%b cnt=%0d", n,
                         mc_busy, mc_done, stall_cnt, (rem > 0), (rem == 1), scnt);
            end
        end
        @(negedge clk);
        reset_n = 1;
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_forward_priority();
        test_load_use();
        test_branch_flush();
        test_mc(1'b0, MUL);
        test_mc(1'b1, DIV);
        test_reset_mid_div();
        test_stall_counter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Next-generation hazard unit for the 5-stage MIPS pipeline, parametrised in register-address width and multi-cycle latencies. Keeps E-stage and D-stage forwarding, load-use stall and branch stall. Adds a tracker for the multi-cycle HI/LO unit (mult/div) with structural and data stalls, a flush_d for taken branches and jumps in place of stalling, and a saturating stall-cycle counter. Sits beside the datapath and controller; it is the only block driving stall and flush controls.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero.
MUL_LAT, 4, cycles the HI/LO unit is busy for mult/multu; at least 1.
DIV_LAT, 32, cycles the HI/LO unit is busy for div/divu; at least 1.
STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
rs_d, rt_d, rs_e, rt_e  in  REG_AW  source registers in D and E
writereg_e, writereg_m, writereg_w  in  REG_AW  destination registers in E, M and W
regwrite_e, regwrite_m, regwrite_w  in  1  register write enables
memtoreg_e, memtoreg_m  in  1  load in stage
branch_d, pcsrc_d, jump_d  in  1  branch in D, branch taken, jump in D
mc_start_d  in  1  mult/div in D
mc_start_e  in  1  mult/div in E; starts the unit
mc_isdiv_e  in  1  E-stage op is div (1) or mult (0)
hilo_rd_d  in  1  mfhi/mflo in D
stat_clr  in  1  clear stall counter
forward_a_e, forward_b_e  out  2  E operand select: 00 register file, 01 W, 10 M
forward_a_d, forward_b_d  out  1  D comparator forward from M
stall_f, stall_d, flush_e, flush_d  out  1  pipeline controls
mc_busy  out  1  HI/LO unit busy
mc_done  out  1  final busy cycle
stall_cnt  out  STALL_CNT_W  stalled-cycle count

Behaviour:
- Forwarding is combinational.
  - forward_x_e = 10 if src≠0, src==writereg_m and regwrite_m.
  - Otherwise 01 if src≠0, src==writereg_w and regwrite_w.
  - Otherwise 00. M has priority over W.
  - forward_x_d = src_d≠0, src_d==writereg_m and regwrite_m.
- lwstall = memtoreg_e & writereg_e≠0 & (rs_d==writereg_e | rt_d==writereg_e).
- branchstall = branch_d & [(regwrite_e & writereg_e≠0 & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m≠0 & writereg_m∈{rs_d,rt_d})]. Jumps never stall.
- HI/LO tracker: FSM with states IDLE and BUSY, plus down-counter cnt (width clog2(max(MUL_LAT,DIV_LAT)+1)).
  - IDLE & mc_start_e: cnt←(mc_isdiv_e ? DIV_LAT : MUL_LAT); go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, go to IDLE next cycle and cnt←0.
  - BUSY & cnt==1 & mc_start_e (back-to-back op released this cycle): reload cnt and stay in BUSY.
  - BUSY & cnt>1 & mc_start_e is a protocol violation. The counter reloads; the bench asserts it never occurs.
  - mc_busy = (state==BUSY). mc_done = BUSY & cnt==1.
- mcstall = (hilo_rd_d | mc_start_d) & (mc_start_e | (mc_busy & cnt>1)).
- Pipeline controls:
  - stall_f = stall_d = flush_e = lwstall | branchstall | mcstall.
  - flush_d = (pcsrc_d | jump_d) & ~stall_d. A stalled branch is flushed only once resolved.
- Stall counter: increments when stall_f=1 and saturates at all-ones. stat_clr has priority over increment (cleared to 0 that cycle).
- Reset (reset_n=0 at a clk edge):
  - state←IDLE, cnt←0, stall_cnt←0. mc_busy and mc_done are 0 the following cycle.
  - Reset mid-operation aborts the tracked op.
  - Combinational outputs follow their inputs during reset.
- Latency:
  - Forwarding, stall and flush outputs: 0 cycles.
  - Tracker and counter: update on the clk edge.
  - A multiply issued to E in cycle t: an mfhi in D stalls in cycles t..t+MUL_LAT-1 and proceeds in cycle t+MUL_LAT.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - mc_state_t enum: IDLE, BUSY.
  - Default latency constants.
- One sub-module, hilo_tracker: FSM, counter, mc_busy/mc_done and the cnt>1 term. Forwarding, stall logic and the stall counter stay in the top.

Test Plan:
- Two-way forward priority: writereg_m=writereg_w=8, both regwrite, rs_e=8 → forward_a_e=10. Then regwrite_m=0 → 01. Then rs_e=0 → 00.
- Load-use: memtoreg_e=1, writereg_e=9, rt_d=9 → stall_f=stall_d=flush_e=1. Same with writereg_e=0 → all 0.
- Branch: branch_d=1, rs_d=4, regwrite_e=1, writereg_e=4 → branchstall. Then pcsrc_d=1 with no stall → flush_d=1 for exactly one cycle.
- Multiply then mfhi: mc_start_e pulse with MUL_LAT=4, hilo_rd_d held → stall for 4 cycles. mc_done on the 4th cycle; mc_busy low after. Repeat with div (DIV_LAT=32) → 32 stall cycles.
- Reset mid-divide: drive reset_n=0 at cnt=17 → mc_busy=0 and stall_cnt=0 the next cycle; mfhi not stalled.
- Counter: STALL_CNT_W=4, hold stall 20 cycles → stall_cnt=15. stat_clr together with stall → 0.
